// File: rtl/i2c_apb_pkg.sv
// Shared register map, STATUS and CMD bit positions for the I2C APB register file.
package i2c_apb_pkg;

  localparam logic [7:0] ADDR_PRESCALE   = 8'h00;
  localparam logic [7:0] ADDR_CMD        = 8'h04;
  localparam logic [7:0] ADDR_SLAVE_ADDR = 8'h08;
  localparam logic [7:0] ADDR_TX_DATA    = 8'h0C;
  localparam logic [7:0] ADDR_RX_DATA    = 8'h10;
  localparam logic [7:0] ADDR_STATUS     = 8'h14;

  localparam int unsigned ST_TX_EMPTY = 0;
  localparam int unsigned ST_TX_FULL  = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_TX_OVF   = 4;
  localparam int unsigned ST_RX_OVF   = 5;
  localparam int unsigned ST_RX_UDF   = 6;

  localparam int unsigned CMD_EN     = 0;
  localparam int unsigned CMD_RSTART = 1;

  typedef struct packed {
    logic tx_ovf;
    logic rx_ovf;
    logic rx_udf;
  } sticky_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra wrap bit to tell full from empty.
module i2c_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  core_clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]           wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  do_push, do_pop;

  always_comb begin
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    do_push  = push & (~full | do_pop);
    overflow = push & full & ~do_pop;
    rdata    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge core_clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/i2c_apb_regfile.sv
// APB register file feeding the I2C controller: config registers, TX/RX byte FIFOs, status.
module i2c_apb_regfile
  import i2c_apb_pkg::*;
#(
  parameter int unsigned          FIFO_DEPTH   = 16,
  parameter int unsigned          DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] PRESCALE_RST = 8'd50
) (
  input  logic                  core_clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [7:0]            paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prescale,
  output logic                  enable,
  output logic                  repeated_start_cond,
  output logic [DATA_WIDTH-1:0] slave_address,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_tx_enable,
  input  logic                  fifo_rx_enable,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  tx_empty,
  output logic                  rx_full
);

  logic [DATA_WIDTH-1:0] prescale_q, slave_q;
  logic [1:0]            cmd_q;
  sticky_t               sticky_q, sticky_d;
  logic                  tx_en_q, rx_en_q;

  logic                  access, err, wr_en, rd_en, wr_status;
  logic                  tx_push, tx_pop, tx_full, tx_fifo_ovf, tx_ovf_set;
  logic                  rx_push, rx_pop, rx_empty, rx_fifo_ovf, rx_udf_set;
  logic [DATA_WIDTH-1:0] rx_head, status, rdata;

  assign access  = psel & penable;
  assign tx_pop  = fifo_tx_enable & ~tx_en_q;
  assign rx_push = fifo_rx_enable & ~rx_en_q;

  always_comb begin
    status              = '0;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_OVF]   = sticky_q.tx_ovf;
    status[ST_RX_OVF]   = sticky_q.rx_ovf;
    status[ST_RX_UDF]   = sticky_q.rx_udf;
  end

  always_comb begin
    rdata = '0;
    err   = 1'b0;
    case (paddr)
      ADDR_PRESCALE:   rdata = prescale_q;
      ADDR_CMD:        rdata = {{(DATA_WIDTH-2){1'b0}}, cmd_q};
      ADDR_SLAVE_ADDR: rdata = slave_q;
      ADDR_TX_DATA:    err   = ~pwrite | tx_full;
      ADDR_RX_DATA: begin
        err = pwrite | rx_empty;
        if (!pwrite) rdata = rx_head;
      end
      ADDR_STATUS:     rdata = status;
      default:         err   = 1'b1;
    endcase
  end

  // Error accesses only ever touch the sticky flag they raise.
  assign wr_en      = access & pwrite & ~err;
  assign rd_en      = access & ~pwrite & ~err;
  assign wr_status  = wr_en & (paddr == ADDR_STATUS);
  assign tx_push    = wr_en & (paddr == ADDR_TX_DATA);
  assign rx_pop     = rd_en & (paddr == ADDR_RX_DATA);
  assign tx_ovf_set = access & pwrite & (paddr == ADDR_TX_DATA) & tx_full;
  assign rx_udf_set = access & ~pwrite & (paddr == ADDR_RX_DATA) & rx_empty;

  always_comb begin
    sticky_d.tx_ovf = (sticky_q.tx_ovf & ~(wr_status & pwdata[ST_TX_OVF])) | tx_ovf_set
                      | tx_fifo_ovf;
    sticky_d.rx_ovf = (sticky_q.rx_ovf & ~(wr_status & pwdata[ST_RX_OVF])) | rx_fifo_ovf;
    sticky_d.rx_udf = (sticky_q.rx_udf & ~(wr_status & pwdata[ST_RX_UDF])) | rx_udf_set;
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      prescale_q <= PRESCALE_RST;
      cmd_q      <= '0;
      slave_q    <= '0;
      sticky_q   <= '0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
    end else begin
      tx_en_q  <= fifo_tx_enable;
      rx_en_q  <= fifo_rx_enable;
      sticky_q <= sticky_d;
      if (wr_en && paddr == ADDR_PRESCALE)   prescale_q <= pwdata;
      if (wr_en && paddr == ADDR_CMD)        cmd_q      <= pwdata[1:0];
      if (wr_en && paddr == ADDR_SLAVE_ADDR) slave_q    <= pwdata;
    end
  end

  i2c_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .core_clk(core_clk),
    .rst     (rst),
    .push    (tx_push),
    .pop     (tx_pop),
    .wdata   (pwdata),
    .rdata   (data_in),
    .full    (tx_full),
    .empty   (tx_empty),
    .overflow(tx_fifo_ovf)
  );

  i2c_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .core_clk(core_clk),
    .rst     (rst),
    .push    (rx_push),
    .pop     (rx_pop),
    .wdata   (rx_data),
    .rdata   (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .overflow(rx_fifo_ovf)
  );

  assign prdata              = rdata;
  assign pready              = 1'b1;
  assign pslverr             = access & err;
  assign prescale            = prescale_q;
  assign enable              = cmd_q[CMD_EN];
  assign repeated_start_cond = cmd_q[CMD_RSTART];
  assign slave_address       = slave_q;

endmodule

// File: tb/tb_i2c_apb_regfile.sv
// Self-checking bench for i2c_apb_regfile: directed scenarios plus randomized traffic vs a queue model.
module tb_i2c_apb_regfile;

  localparam int DEPTH = 16;

  logic       core_clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = 8'h00, pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic [7:0] prescale, slave_address, data_in;
  logic       enable, repeated_start_cond;
  logic       fifo_tx_enable = 1'b0, fifo_rx_enable = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_empty, rx_full;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] m_prescale, m_slave;
  logic [1:0] m_cmd;
  logic       m_txovf, m_rxovf, m_udf;

  i2c_apb_regfile dut (
    .core_clk           (core_clk),
    .rst                (rst),
    .psel               (psel),
    .penable            (penable),
    .pwrite             (pwrite),
    .paddr              (paddr),
    .pwdata             (pwdata),
    .prdata             (prdata),
    .pready             (pready),
    .pslverr            (pslverr),
    .prescale           (prescale),
    .enable             (enable),
    .repeated_start_cond(repeated_start_cond),
    .slave_address      (slave_address),
    .data_in            (data_in),
    .fifo_tx_enable     (fifo_tx_enable),
    .fifo_rx_enable     (fifo_rx_enable),
    .rx_data            (rx_data),
    .tx_empty           (tx_empty),
    .rx_full            (rx_full)
  );

  always #5 core_clk = ~core_clk;

  function automatic void m_reset();
    tx_q.delete();
    rx_q.delete();
    m_prescale = 8'h32;
    m_slave    = 8'h00;
    m_cmd      = 2'b00;
    m_txovf    = 1'b0;
    m_rxovf    = 1'b0;
    m_udf      = 1'b0;
  endfunction

  function automatic logic [7:0] m_status();
    return {1'b0, m_udf, m_rxovf, m_txovf, rx_q.size() == DEPTH, rx_q.size() == 0,
            tx_q.size() == DEPTH, tx_q.size() == 0};
  endfunction

  function automatic void model_apb(input logic w, input logic [7:0] a, input logic [7:0] d,
                                    output logic [7:0] rd, output logic er);
    rd = 8'h00;
    er = 1'b0;
    case (a)
      8'h00: if (w) m_prescale = d; else rd = m_prescale;
      8'h04: if (w) m_cmd = d[1:0]; else rd = {6'b0, m_cmd};
      8'h08: if (w) m_slave = d; else rd = m_slave;
      8'h0C: begin
        if (!w) er = 1'b1;
        else if (tx_q.size() == DEPTH) begin er = 1'b1; m_txovf = 1'b1; end
        else tx_q.push_back(d);
      end
      8'h10: begin
        if (w) er = 1'b1;
        else if (rx_q.size() == 0) begin er = 1'b1; m_udf = 1'b1; end
        else rd = rx_q.pop_front();
      end
      8'h14: begin
        if (w) begin
          if (d[4]) m_txovf = 1'b0;
          if (d[5]) m_rxovf = 1'b0;
          if (d[6]) m_udf = 1'b0;
        end else rd = m_status();
      end
      default: er = 1'b1;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge core_clk);
    rst = 1'b1; psel = 1'b0; penable = 1'b0; fifo_tx_enable = 1'b0; fifo_rx_enable = 1'b0;
    @(negedge core_clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic apb(input logic w, input logic [7:0] a, input logic [7:0] d,
                     output logic [7:0] rd, output logic er);
    @(negedge core_clk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(negedge core_clk);
    penable = 1'b1;
    #1;
    rd = prdata;
    er = pslverr;
    @(negedge core_clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic pulse_tx(input int len);
    @(negedge core_clk);
    fifo_tx_enable = 1'b1;
    repeat (len) @(negedge core_clk);
    fifo_tx_enable = 1'b0;
    @(negedge core_clk);
  endtask

  task automatic pulse_rx(input logic [7:0] d, input int len);
    @(negedge core_clk);
    rx_data = d;
    fifo_rx_enable = 1'b1;
    repeat (len) @(negedge core_clk);
    fifo_rx_enable = 1'b0;
    @(negedge core_clk);
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    logic       er;
    logic [7:0] addrs[4];
    logic [7:0] exps[4];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h14};
    exps  = '{8'h32, 8'h00, 8'h00, 8'h05};
    do_reset();
    vectors++;
    if ({data_in, enable, repeated_start_cond, tx_empty, rx_full} !== {8'h00, 4'b0010}) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h/%b%b%b%b exp=00/0010", data_in, enable,
               repeated_start_cond, tx_empty, rx_full);
    end
    for (int i = 0; i < 4; i++) begin
      apb(1'b0, addrs[i], 8'h00, rd, er);
      vectors++;
      if (rd !== exps[i] || er !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_read addr=%h got=%h err=%b exp=%h err=0", addrs[i], rd, er, exps[i]);
      end
    end
  endtask

  task automatic test_tx_pop();
    logic [7:0] rd;
    logic       er;
    do_reset();
    apb(1'b1, 8'h0C, 8'hA1, rd, er);
    apb(1'b1, 8'h0C, 8'hB2, rd, er);
    vectors++;
    if (data_in !== 8'hA1 || tx_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_head_before got=%h/%b exp=a1/0", data_in, tx_empty);
    end
    pulse_tx(5);
    vectors++;
    if (data_in !== 8'hB2 || tx_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_head_after_pop got=%h/%b exp=b2/0", data_in, tx_empty);
    end
  endtask

  task automatic test_tx_overflow();
    logic [7:0] rd;
    logic       er;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      apb(1'b1, 8'h0C, 8'(i), rd, er);
      vectors++;
      if (er !== (i == DEPTH)) begin
        miscompares++;
        $display("FAIL tx_fill_err idx=%0d got=%b exp=%b", i, er, i == DEPTH);
      end
    end
    apb(1'b0, 8'h14, 8'h00, rd, er);
    vectors++;
    if (rd !== 8'h16) begin
      miscompares++;
      $display("FAIL tx_ovf_status got=%h exp=16", rd);
    end
    apb(1'b1, 8'h14, 8'h10, rd, er);
    apb(1'b0, 8'h14, 8'h00, rd, er);
    vectors++;
    if (rd !== 8'h06) begin
      miscompares++;
      $display("FAIL tx_ovf_w1c got=%h exp=06", rd);
    end
  endtask

  task automatic test_rx_underflow();
    logic [7:0] rd;
    logic       er;
    do_reset();
    pulse_rx(8'h5C, 3);
    apb(1'b0, 8'h10, 8'h00, rd, er);
    vectors++;
    if (rd !== 8'h5C || er !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_read_first got=%h/%b exp=5c/0", rd, er);
    end
    apb(1'b0, 8'h10, 8'h00, rd, er);
    vectors++;
    if (rd !== 8'h00 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_read_empty got=%h/%b exp=00/1", rd, er);
    end
    apb(1'b0, 8'h14, 8'h00, rd, er);
    vectors++;
    if (rd !== 8'h45) begin
      miscompares++;
      $display("FAIL rx_udf_status got=%h exp=45", rd);
    end
  endtask

  task automatic test_rx_full_simul();
    logic [7:0] rd;
    logic       er;
    do_reset();
    for (int i = 0; i < DEPTH; i++) pulse_rx(8'(8'h20 + i), 1);
    // APB pop and controller push in the very same access cycle
    @(negedge core_clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
    @(negedge core_clk);
    penable = 1'b1; rx_data = 8'h77; fifo_rx_enable = 1'b1;
    #1;
    rd = prdata;
    er = pslverr;
    @(negedge core_clk);
    psel = 1'b0; penable = 1'b0; fifo_rx_enable = 1'b0;
    vectors++;
    if (rd !== 8'h20 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_simul_read got=%h/%b exp=20/0", rd, er);
    end
    apb(1'b0, 8'h14, 8'h00, rd, er);
    vectors++;
    if (rd !== 8'h09 || rx_full !== 1'b1) begin
      miscompares++;
      $display("FAIL rx_simul_status got=%h/%b exp=09/1", rd, rx_full);
    end
    pulse_rx(8'h88, 1);
    apb(1'b0, 8'h14, 8'h00, rd, er);
    vectors++;
    if (rd !== 8'h29) begin
      miscompares++;
      $display("FAIL rx_ovf_status got=%h exp=29", rd);
    end
    for (int i = 0; i < DEPTH; i++) begin
      apb(1'b0, 8'h10, 8'h00, rd, er);
      vectors++;
      if (rd !== ((i == DEPTH - 1) ? 8'h77 : 8'(8'h21 + i)) || er !== 1'b0) begin
        miscompares++;
        $display("FAIL rx_drain idx=%0d got=%h/%b exp=%h/0", i, rd, er,
                 (i == DEPTH - 1) ? 8'h77 : 8'(8'h21 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    logic       er;
    do_reset();
    apb(1'b1, 8'h04, 8'h03, rd, er);
    apb(1'b1, 8'h0C, 8'h11, rd, er);
    apb(1'b1, 8'h0C, 8'h22, rd, er);
    apb(1'b1, 8'h0C, 8'h33, rd, er);
    vectors++;
    if ({enable, repeated_start_cond, tx_empty, data_in} !== {3'b110, 8'h11}) begin
      miscompares++;
      $display("FAIL pre_reset got=%b%b%b/%h exp=110/11", enable, repeated_start_cond,
               tx_empty, data_in);
    end
    @(negedge core_clk);
    fifo_tx_enable = 1'b1;
    @(negedge core_clk);
    rst = 1'b1;
    @(negedge core_clk);
    rst = 1'b0;
    fifo_tx_enable = 1'b0;
    @(negedge core_clk);
    m_reset();
    vectors++;
    if ({enable, repeated_start_cond, tx_empty, data_in} !== {3'b001, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_reset got=%b%b%b/%h exp=001/00", enable, repeated_start_cond,
               tx_empty, data_in);
    end
  endtask

  task automatic test_random();
    logic [7:0]  rd, erd, a, d;
    logic        er, eer, w;
    logic [26:0] got, exp;
    int          k;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      if (k < 5) begin
        case ($urandom_range(0, 7))
          0: a = 8'h00;
          1: a = 8'h04;
          2: a = 8'h08;
          3: a = 8'h0C;
          4: a = 8'h10;
          5: a = 8'h14;
          6: a = 8'h0C;
          default: a = 8'h15 + 8'($urandom_range(0, 200));
        endcase
        w = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        apb(w, a, d, rd, er);
        model_apb(w, a, d, erd, eer);
        vectors++;
        if (er !== eer) begin
          miscompares++;
          $display("FAIL rand_err step=%0d addr=%h w=%b got=%b exp=%b", n, a, w, er, eer);
        end
        if (!w) begin
          vectors++;
          if (rd !== erd) begin
            miscompares++;
            $display("FAIL rand_rdata step=%0d addr=%h got=%h exp=%h", n, a, rd, erd);
          end
        end
      end else if (k < 7) begin
        pulse_tx($urandom_range(1, 4));
        if (tx_q.size() != 0) void'(tx_q.pop_front());
      end else if (k < 9) begin
        d = 8'($urandom);
        pulse_rx(d, $urandom_range(1, 4));
        if (rx_q.size() == DEPTH) m_rxovf = 1'b1;
        else rx_q.push_back(d);
      end
      exp = {m_prescale, m_slave, (tx_q.size() != 0) ? tx_q[0] : 8'h00, m_cmd[0], m_cmd[1],
             tx_q.size() == 0, rx_q.size() == DEPTH};
      got = {prescale, slave_address, data_in, enable, repeated_start_cond, tx_empty, rx_full};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL rand_outputs step=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_pop();
    test_tx_overflow();
    test_rx_underflow();
    test_rx_full_simul();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
